osd_wr_scheduler: RTL

// - Arbitrates OSD text-RAM writes from two requesters: the NIOS II CPU (toggle handshake, SYS_CLK origin) and a hardware status writer (req/gnt).
// - Issues writes in the N64_CLK_i domain, only inside the blanking window osd_wr_win_i.
// - Rate-limits writes (gap) and caps writes per window (budget) so OSD updates never tear an active frame.

---
 rtl/osd_wr_scheduler.sv | 126 ++++++++++++
 1 files changed

// File: rtl/osd_wr_scheduler.sv
// Arbitrates OSD text-RAM writes from a CPU toggle handshake and a HW req/gnt port,
// issuing them only inside the blanking window with a strobe gap and a per-window cap.
module osd_wr_scheduler #(
  parameter int WR_GAP    = 2,
  parameter int MAX_WR    = 64,
  parameter int CPU_FIRST = 1
) (
  input  logic        N64_CLK_i,
  input  logic        CTRL_nRST,
  input  logic        cpu_wr_tgl_i,
  input  logic [19:0] cpu_wr_data_i,
  output logic        cpu_wr_ack_o,
  input  logic        hw_req_i,
  input  logic [19:0] hw_data_i,
  output logic        hw_gnt_o,
  input  logic        osd_wr_win_i,
  output logic        osd_we_o,
  output logic [19:0] osd_wdata_o
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP} state_t;

  localparam logic [7:0] BUDGET_MAX = 8'(MAX_WR);
  localparam logic [3:0] GAP_LAST   = (WR_GAP > 0) ? 4'(WR_GAP - 1) : 4'd0;
  localparam logic       LAST_RST   = (CPU_FIRST == 0);

  state_t      r_state;
  state_t      w_state_next;
  logic        w_grant;
  logic        r_tgl_s1, r_tgl_s2, r_tgl_prev;
  logic        r_cpu_pend;
  logic [19:0] r_cpu_buf;
  logic        r_win;
  logic [7:0]  r_budget;
  logic [3:0]  r_gap_cnt;
  logic        r_last_cpu;
  logic        r_we, r_gnt, r_ack;
  logic [19:0] r_wdata;
  logic        w_cpu_edge, w_win_rise, w_exhausted, w_pick_cpu;

  assign w_cpu_edge  = r_tgl_s2 ^ r_tgl_prev;
  assign w_win_rise  = osd_wr_win_i & ~r_win;
  assign w_exhausted = (r_budget == BUDGET_MAX);
  // On a tie the requester that did not win last time goes first.
  assign w_pick_cpu  = r_cpu_pend & (~hw_req_i | ~r_last_cpu);

  always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
    if (!CTRL_nRST) r_state <= S_IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_win && !w_exhausted && (r_cpu_pend || hw_req_i)) begin
          w_grant      = 1'b1;
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (WR_GAP > 0) w_state_next = S_GAP;
        else            w_state_next = S_IDLE;
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
    if (!CTRL_nRST) begin
      r_tgl_s1   <= 1'b0;
      r_tgl_s2   <= 1'b0;
      r_tgl_prev <= 1'b0;
      r_cpu_pend <= 1'b0;
      r_cpu_buf  <= 20'd0;
      r_win      <= 1'b0;
      r_budget   <= 8'd0;
      r_gap_cnt  <= 4'd0;
      r_last_cpu <= LAST_RST;
      r_we       <= 1'b0;
      r_gnt      <= 1'b0;
      r_ack      <= 1'b0;
      r_wdata    <= 20'd0;
    end else begin
      r_tgl_s1   <= cpu_wr_tgl_i;
      r_tgl_s2   <= r_tgl_s1;
      r_tgl_prev <= r_tgl_s2;
      r_win      <= osd_wr_win_i;

      // Edges arriving while a request is still pending are dropped.
      if (w_grant && w_pick_cpu) begin
        r_cpu_pend <= 1'b0;
      end else if (w_cpu_edge && !r_cpu_pend) begin
        r_cpu_pend <= 1'b1;
        r_cpu_buf  <= cpu_wr_data_i;
      end

      r_we  <= w_grant;
      r_gnt <= w_grant & ~w_pick_cpu;
      if (w_grant) begin
        r_wdata    <= w_pick_cpu ? r_cpu_buf : hw_data_i;
        r_last_cpu <= w_pick_cpu;
        if (w_pick_cpu) r_ack <= r_tgl_s2;
      end

      // A window restart coinciding with a write counts that write in the new window.
      if (w_win_rise)
        r_budget <= (r_state == S_WRITE) ? 8'd1 : 8'd0;
      else if (r_state == S_WRITE && !w_exhausted)
        r_budget <= r_budget + 8'd1;

      if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + 4'd1;
      else                  r_gap_cnt <= 4'd0;
    end
  end

  assign osd_we_o     = r_we;
  assign hw_gnt_o     = r_gnt;
  assign cpu_wr_ack_o = r_ack;
  assign osd_wdata_o  = r_wdata;

endmodule
